bcd_hex_display: RTL and testbench

//  Sequential binary-to-decimal display driver for the board's active-low 7-seg HEX displays.
//  - Converts a BIN_W-bit unsigned value to DIGITS decimal digits by double-dabble, one shift per clock.
//  - Drives one 7-seg pattern per digit, covering 0-9, blank and overflow dash.
//  - Sits between switch/counter logic and the HEX pins; replaces per-nibble combinational decoding for multi-digit decimal readout.

---
 rtl/bcd_hex_pkg.sv | 14 +
 rtl/bcd_hex_display_if.sv | 16 +
 rtl/bcd_hex_display_seg7_digit.sv | 13 +
 rtl/bcd_hex_display.sv | 118 +++++++++++
 tb/tb_bcd_hex_display.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/bcd_hex_pkg.sv
// Shared constants, FSM states and the double-dabble nibble correction for bcd_hex_display.
package bcd_hex_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  // Active-low {g..a} patterns, entry 0 at the least significant slice.
  localparam logic [9:0][6:0] SEG_TBL = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                         7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction
endpackage

// File: rtl/bcd_hex_display_if.sv
// Request/result bundle between the value source and bcd_hex_display.
interface bcd_hex_display_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   hex;

  modport master (output start, bin_in, input  busy, done, ovf, bcd_out, hex);
  modport slave  (input  start, bin_in, output busy, done, ovf, bcd_out, hex);
endinterface

// File: rtl/bcd_hex_display_seg7_digit.sv
// Combinational BCD digit to active-low 7-seg pattern, with a blank override.
import bcd_hex_pkg::*;

module seg7_digit (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && i_bcd <= 4'd9) o_seg = SEG_TBL[i_bcd];
  end
endmodule

// File: rtl/bcd_hex_display.sv
// Sequential double-dabble binary-to-decimal converter driving active-low HEX displays.
// Define BCD_HEX_LZ_BLANK_EN to blank leading zero digits.
import bcd_hex_pkg::*;

module bcd_hex_display #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             resetn,
  bcd_hex_display_if.slave bus
);
  localparam int ACC_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t                     r_state, w_next;
  logic [CNT_W-1:0]           r_cnt;
  logic [ACC_W-1:0]           r_acc;
  logic [BIN_W-1:0]           r_bin;
  logic                       r_sticky;
  logic                       r_done, r_ovf;
  logic [DIGITS-1:0][3:0]     r_bcd;
  logic [DIGITS-1:0][6:0]     r_hex;

  logic [ACC_W-1:0]           w_acc_adj;
  logic [DIGITS-1:0][6:0]     w_seg;
  logic [DIGITS-1:0]          w_blank;
  logic                       w_bad, w_ovf;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(BIN_W - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < DIGITS + 1; i++) begin : g_adj
    assign w_acc_adj[4*i +: 4] = add3_if_ge5(r_acc[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_bin    <= '0;
      r_sticky <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_bin    <= bus.bin_in;
      r_sticky <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc    <= {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
      r_bin    <= r_bin << 1;
      // Once the guard nibble holds anything the value already exceeds the display range.
      r_sticky <= r_sticky | (|w_acc_adj[ACC_W-1 -: 4]);
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      if (r_acc[4*d +: 4] > 4'd9) w_bad = 1'b1;
  end
  assign w_ovf = r_sticky | (|r_acc[ACC_W-1 -: 4]) | w_bad;

`ifdef BCD_HEX_LZ_BLANK_EN
  logic [DIGITS-1:0] w_lz;
  for (genvar d = 0; d < DIGITS; d++) begin : g_lz
    if (d == DIGITS - 1) begin : g_top
      assign w_lz[d] = (r_acc[4*d +: 4] == 4'd0);
    end else begin : g_mid
      assign w_lz[d] = w_lz[d+1] & (r_acc[4*d +: 4] == 4'd0);
    end
    assign w_blank[d] = (d != 0) && w_lz[d];
  end
`else
  assign w_blank = '0;
`endif

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    seg7_digit u_seg (
      .i_bcd   (r_acc[4*d +: 4]),
      .i_blank (w_blank[d]),
      .o_seg   (w_seg[d])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_bcd  <= '0;
      r_hex  <= {DIGITS{SEG_BLANK}};
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_ovf <= w_ovf;
        r_bcd <= w_ovf ? {DIGITS{4'h9}} : r_acc[4*DIGITS-1:0];
        r_hex <= w_ovf ? {DIGITS{SEG_DASH}} : w_seg;
      end
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.ovf     = r_ovf;
  assign bus.bcd_out = r_bcd;
  assign bus.hex     = r_hex;
endmodule

// File: tb/tb_bcd_hex_display.sv
// Directed bench for bcd_hex_display: 3-digit and 2-digit instances, 8-bit input.
module tb_bcd_hex_display;
`ifdef BCD_HEX_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bcd_hex_display_if #(.BIN_W(8), .DIGITS(3)) if3 ();
  bcd_hex_display_if #(.BIN_W(8), .DIGITS(2)) if2 ();

  bcd_hex_display #(.BIN_W(8), .DIGITS(3)) u_dut3 (.clk(clk), .resetn(resetn), .bus(if3.slave));
  bcd_hex_display #(.BIN_W(8), .DIGITS(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(if2.slave));

  int n_chk = 0;
  int n_pass = 0;

  // Start a conversion on the selected instance and wait (bounded) for done.
  task automatic convert(input bit sel2, input logic [7:0] v, output int edges);
    @(posedge clk); #1;
    if (sel2) begin if2.start = 1'b1; if2.bin_in = v; end
    else      begin if3.start = 1'b1; if3.bin_in = v; end
    @(posedge clk); #1;
    if2.start = 1'b0; if3.start = 1'b0;
    edges = 0;
    while (((sel2 ? if2.done : if3.done) !== 1'b1) && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    if3.start = 1'b0; if3.bin_in = '0; if2.start = 1'b0; if2.bin_in = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({if3.busy, if3.done, if3.ovf} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {if3.busy, if3.done, if3.ovf}); else n_pass++;
    n_chk++; if (if3.bcd_out !== 12'h000) $display("FAIL reset_bcd got %h want 000", if3.bcd_out); else n_pass++;
    n_chk++; if (if3.hex !== {3{7'h7F}}) $display("FAIL reset_hex got %h want %h", if3.hex, {3{7'h7F}}); else n_pass++;
    n_chk++; if (if2.hex !== {2{7'h7F}} || if2.bcd_out !== 8'h00)
      $display("FAIL reset_dut2 got hex %h bcd %h", if2.hex, if2.bcd_out); else n_pass++;
  endtask

  task automatic test_max();
    int e;
    convert(1'b0, 8'd255, e);
    n_chk++; if (e !== 9) $display("FAIL lat255 got %0d want 9", e); else n_pass++;
    n_chk++; if (if3.bcd_out !== 12'h255) $display("FAIL bcd255 got %h want 255", if3.bcd_out); else n_pass++;
    n_chk++; if (if3.hex !== {7'h24, 7'h12, 7'h12}) $display("FAIL hex255 got %h want %h", if3.hex, {7'h24, 7'h12, 7'h12}); else n_pass++;
    n_chk++; if (if3.ovf !== 1'b0 || if3.busy !== 1'b0) $display("FAIL ovfbusy255 got %b%b want 00", if3.ovf, if3.busy); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (if3.done !== 1'b0) $display("FAIL done_pulse got %b want 0", if3.done); else n_pass++;
  endtask

  task automatic test_lead_zero();
    int e;
    logic [20:0] exp;
    convert(1'b0, 8'd7, e);
    exp = LZ ? {7'h7F, 7'h7F, 7'h78} : {7'h40, 7'h40, 7'h78};
    n_chk++; if (if3.hex !== exp || if3.bcd_out !== 12'h007) $display("FAIL hex7 got %h/%h want %h/007", if3.hex, if3.bcd_out, exp); else n_pass++;
    convert(1'b0, 8'd0, e);
    exp = LZ ? {7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40};
    n_chk++; if (if3.hex !== exp || if3.bcd_out !== 12'h000) $display("FAIL hex0 got %h/%h want %h/000", if3.hex, if3.bcd_out, exp); else n_pass++;
    convert(1'b0, 8'd100, e);
    n_chk++; if (if3.hex !== {7'h79, 7'h40, 7'h40}) $display("FAIL hex100 got %h want %h", if3.hex, {7'h79, 7'h40, 7'h40}); else n_pass++;
    convert(1'b0, 8'd36, e);
    exp = LZ ? {7'h7F, 7'h30, 7'h02} : {7'h40, 7'h30, 7'h02};
    n_chk++; if (if3.hex !== exp || if3.bcd_out !== 12'h036) $display("FAIL hex36 got %h/%h want %h/036", if3.hex, if3.bcd_out, exp); else n_pass++;
  endtask

  task automatic test_overflow();
    int e;
    convert(1'b1, 8'd100, e);
    n_chk++; if (if2.ovf !== 1'b1 || if2.bcd_out !== 8'h99) $display("FAIL ovf100 got %b/%h want 1/99", if2.ovf, if2.bcd_out); else n_pass++;
    n_chk++; if (if2.hex !== {7'h3F, 7'h3F}) $display("FAIL dash100 got %h want %h", if2.hex, {7'h3F, 7'h3F}); else n_pass++;
    convert(1'b1, 8'd42, e);
    n_chk++; if (if2.ovf !== 1'b0 || if2.bcd_out !== 8'h42) $display("FAIL ovf42 got %b/%h want 0/42", if2.ovf, if2.bcd_out); else n_pass++;
    n_chk++; if (if2.hex !== {7'h19, 7'h24}) $display("FAIL hex42 got %h want %h", if2.hex, {7'h19, 7'h24}); else n_pass++;
    convert(1'b1, 8'd99, e);
    n_chk++; if (if2.ovf !== 1'b0 || if2.bcd_out !== 8'h99 || if2.hex !== {7'h10, 7'h10})
      $display("FAIL edge99 got %b/%h/%h want 0/99/%h", if2.ovf, if2.bcd_out, if2.hex, {7'h10, 7'h10}); else n_pass++;
    convert(1'b1, 8'd255, e);
    n_chk++; if (if2.ovf !== 1'b1 || if2.bcd_out !== 8'h99) $display("FAIL ovf255 got %b/%h want 1/99", if2.ovf, if2.bcd_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dones = 0, first = 0, hold_err = 0;
    logic [11:0] prev;
    prev = if3.bcd_out;
    @(posedge clk); #1;
    if3.start = 1'b1; if3.bin_in = 8'd128;
    @(posedge clk); #1;
    if3.start = 1'b0; if3.bin_in = 8'd1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 3) if3.start = 1'b1;
      if (i == 5) if3.start = 1'b0;
      if (if3.done === 1'b1) begin dones++; if (first == 0) first = i; end
      if (i < 9 && if3.bcd_out !== prev) hold_err++;
      if (i == 9) if3.start = 1'b0;
    end
    n_chk++; if (dones !== 1 || first !== 9) $display("FAIL b2b_dones got %0d at %0d want 1 at 9", dones, first); else n_pass++;
    n_chk++; if (if3.bcd_out !== 12'h128) $display("FAIL b2b_bcd got %h want 128", if3.bcd_out); else n_pass++;
    n_chk++; if (hold_err !== 0) $display("FAIL hold got %0d changes want 0", hold_err); else n_pass++;
  endtask

  task automatic test_abort();
    int dones = 0, e;
    logic [20:0] exp;
    @(posedge clk); #1;
    if3.start = 1'b1; if3.bin_in = 8'd200;
    @(posedge clk); #1;
    if3.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    n_chk++; if ({if3.busy, if3.done, if3.ovf} !== 3'b000 || if3.bcd_out !== 12'h000 || if3.hex !== {3{7'h7F}})
      $display("FAIL abort_state got %b/%h/%h want 000/000/%h", {if3.busy, if3.done, if3.ovf}, if3.bcd_out, if3.hex, {3{7'h7F}}); else n_pass++;
    @(posedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (if3.done === 1'b1) dones++;
    end
    n_chk++; if (dones !== 0 || if3.bcd_out !== 12'h000) $display("FAIL abort_nodone got %0d/%h want 0/000", dones, if3.bcd_out); else n_pass++;
    convert(1'b0, 8'd42, e);
    exp = LZ ? {7'h7F, 7'h19, 7'h24} : {7'h40, 7'h19, 7'h24};
    n_chk++; if (e !== 9 || if3.bcd_out !== 12'h042 || if3.hex !== exp)
      $display("FAIL post_abort got %0d/%h/%h want 9/042/%h", e, if3.bcd_out, if3.hex, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_max();
    test_lead_zero();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
